// File: rtl/clock_pio_pkg.sv
// Shared types and constants for the clock PIO sequencer.
package clock_pio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_MIN  = 2'd1,
        WR_HOUR = 2'd2
    } state_e;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;

    localparam logic [1:0] PIO_ADDR = 2'd0;

    function automatic logic time_in_range(input logic [7:0] hour, input logic [7:0] minute);
        return (hour < 8'(HOURS_PER_DAY)) && (minute < 8'(MIN_PER_HOUR));
    endfunction

endpackage

// File: rtl/clock_pio_sequencer_mod_counter.sv
// Modulo-N counter with synchronous load; wrap flags the increment that returns it to 0.
module mod_counter #(
    parameter int MODULUS = 60,
    parameter int W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority, so a loading cycle never reports a carry.
    assign wrap  = inc && !load && (count_q == W'(MODULUS - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clock_pio_sequencer.sv
// Timekeeper that writes MINUTE then HOUR PIO slaves on every minute change or accepted set.
module clock_pio_sequencer
    import clock_pio_pkg::*;
#(
    parameter int SEC_PER_MIN = 60,
    parameter int WDATA_W     = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick_1hz,
    input  logic               set_req,
    input  logic [7:0]         set_hour,
    input  logic [7:0]         set_min,
    output logic               set_ack,
    output logic               set_err,
    input  logic               alarm_en,
    input  logic [7:0]         alarm_hour,
    input  logic [7:0]         alarm_min,
    output logic               alarm_pulse,
    output logic               busy,
    output logic [1:0]         pio_address,
    output logic               pio_write_n,
    output logic [WDATA_W-1:0] pio_writedata,
    output logic               min_chipselect,
    output logic               hour_chipselect
);

    localparam int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;

    state_e state_q, state_d;
    logic   tick_pend_q, tick_pend_d;
    logic   roll_q, roll_d;
    logic   set_ack_q, set_ack_d;
    logic   set_err_q, set_err_d;
    logic   alarm_pulse_q, alarm_pulse_d;

    logic             idle;
    logic             do_tick;
    logic             do_load;
    logic [SEC_W-1:0] sec_cnt;
    logic [5:0]       min_cnt;
    logic [4:0]       hour_cnt;
    logic             sec_wrap;
    logic             min_wrap;
    logic             day_wrap_unused;

    // A set request in IDLE always pre-empts a tick, new or pending.
    assign idle    = (state_q == IDLE);
    assign do_tick = idle && !set_req && (tick_1hz || tick_pend_q);
    assign do_load = idle && set_req && time_in_range(set_hour, set_min);

    mod_counter #(.MODULUS(SEC_PER_MIN), .W(SEC_W)) u_sec (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (do_tick),
        .load     (do_load),
        .load_val ('0),
        .count    (sec_cnt),
        .wrap     (sec_wrap)
    );

    mod_counter #(.MODULUS(MIN_PER_HOUR), .W(6)) u_min (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (sec_wrap),
        .load     (do_load),
        .load_val (set_min[5:0]),
        .count    (min_cnt),
        .wrap     (min_wrap)
    );

    mod_counter #(.MODULUS(HOURS_PER_DAY), .W(5)) u_hour (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (min_wrap),
        .load     (do_load),
        .load_val (set_hour[4:0]),
        .count    (hour_cnt),
        .wrap     (day_wrap_unused)
    );

    always_comb begin
        state_d       = state_q;
        tick_pend_d   = tick_pend_q;
        roll_d        = roll_q;
        set_ack_d     = 1'b0;
        set_err_d     = 1'b0;
        alarm_pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (set_req) begin
                    set_ack_d   = 1'b1;
                    set_err_d   = !do_load;
                    tick_pend_d = 1'b0;
                    if (do_load) begin
                        roll_d  = 1'b0;
                        state_d = WR_MIN;
                    end
                end else if (do_tick) begin
                    // Only a simultaneous new tick can remain pending after one is applied.
                    tick_pend_d = tick_1hz && tick_pend_q;
                    if (sec_wrap) begin
                        roll_d  = 1'b1;
                        state_d = WR_MIN;
                    end
                end
            end
            WR_MIN: begin
                state_d       = WR_HOUR;
                tick_pend_d   = tick_pend_q || tick_1hz;
                alarm_pulse_d = roll_q && alarm_en
                             && ({3'b000, hour_cnt} == alarm_hour)
                             && ({2'b00, min_cnt} == alarm_min);
            end
            WR_HOUR: begin
                state_d     = IDLE;
                tick_pend_d = tick_pend_q || tick_1hz;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            tick_pend_q   <= 1'b0;
            roll_q        <= 1'b0;
            set_ack_q     <= 1'b0;
            set_err_q     <= 1'b0;
            alarm_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_pend_q   <= tick_pend_d;
            roll_q        <= roll_d;
            set_ack_q     <= set_ack_d;
            set_err_q     <= set_err_d;
            alarm_pulse_q <= alarm_pulse_d;
        end
    end

    // Bus signals decode straight from state and counter registers; nothing in IDLE.
    always_comb begin
        pio_writedata = '0;
        unique case (state_q)
            WR_MIN:  pio_writedata = WDATA_W'(min_cnt);
            WR_HOUR: pio_writedata = WDATA_W'(hour_cnt);
            default: pio_writedata = '0;
        endcase
    end

    assign min_chipselect  = (state_q == WR_MIN);
    assign hour_chipselect = (state_q == WR_HOUR);
    assign pio_write_n     = !(min_chipselect || hour_chipselect);
    assign pio_address     = PIO_ADDR;
    assign busy            = !idle;
    assign set_ack         = set_ack_q;
    assign set_err         = set_err_q;
    assign alarm_pulse     = alarm_pulse_q;

endmodule
